clock_set_ctrl: RTL and testbench
=================================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter LOAD_CYCLES, default 2: number of consecutive clk cycles time_ow is held high per load.
REQ-002 Parameter TIMEOUT_S, default 30: idle seconds in an edit state before the edit is abandoned.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 tick_1hz  in  1  one-cycle pulse, once per second, synchronous to clk.
REQ-007 mode_btn  in  1  debounced single-cycle press: enter edit / advance field / commit.
REQ-008 inc_btn  in  1  debounced single-cycle press: increment the selected field.
REQ-009 time_out  in  17  live clock time, packed {hour[4:0], min[5:0], sec[5:0]}.
REQ-010 time_ow  out  1  overwrite strobe to the clock, active high.
REQ-011 time_in  out  17  time to load, same packing as time_out.
REQ-012 edit_field  out  2  0=none, 1=hour, 2=minute, 3=second.
REQ-013 blink  out  1  display blink for the selected field.
REQ-014 busy  out  1  high in any state other than RUN.

Function
REQ-015 FSM states SHALL be RUN, SET_HR, SET_MIN, SET_SEC, LOAD.
REQ-016 RUN + mode_btn -> SET_HR next cycle; edit register captures time_out in that same cycle.
REQ-017 Any captured field above its maximum (hour>23, min/sec>59) SHALL be replaced with 0.
REQ-018 SET_HR + mode_btn -> SET_MIN; SET_MIN + mode_btn -> SET_SEC; SET_SEC + mode_btn -> LOAD.
REQ-019 inc_btn in SET_x SHALL increment only that field by 1: hour 23->0, min/sec 59->0; no carry into other fields.
REQ-020 mode_btn and inc_btn in the same cycle: mode_btn SHALL act and inc_btn SHALL be ignored.
REQ-021 LOAD: time_ow SHALL be high for exactly LOAD_CYCLES cycles starting the cycle after entry, then the FSM returns to RUN.
REQ-022 time_in SHALL equal the edit register throughout LOAD and hold that value afterwards until the next load.
REQ-023 Both buttons SHALL be ignored in LOAD; inc_btn SHALL be ignored in RUN.
REQ-024 Idle counter: cleared on any button press and on entry to SET_HR; incremented on tick_1hz in SET_x; on reaching TIMEOUT_S -> RUN with no time_ow pulse.
REQ-025 blink SHALL toggle on each tick_1hz in SET_x, and SHALL be 0 in RUN and LOAD and on every state entry.
REQ-026 edit_field SHALL be 1/2/3 in SET_HR/SET_MIN/SET_SEC, else 0; busy = (state != RUN).

Reset
REQ-027 rst_n low SHALL immediately force: state RUN, time_ow 0, time_in 0, edit register 0, edit_field 0, blink 0, busy 0, idle counter 0, LOAD counter 0.
REQ-028 Reset asserted during LOAD SHALL drop time_ow at once; no partial load resumes after release.

Structure
REQ-029 Shared package clock_ctrl_pkg SHALL hold the state enum, field widths (5/6/6), HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59 and the field-select encoding.
REQ-030 Sub-module field_wrap_inc (value, max -> value+1 wrapping to 0) SHALL be instantiated per field; everything else stays in clock_set_ctrl.

Verification
REQ-031 time_out=12:34:56, mode -> edit reg 12:34:56, edit_field=1; 3x inc, mode, mode, mode -> time_ow high exactly 2 cycles, time_in=15:34:56.
REQ-032 Hour 23 + inc -> 0; minute 59 + inc -> 0, hour unchanged; second 59 + inc -> 0.
REQ-033 mode and inc same cycle in SET_MIN -> SET_SEC, minute unchanged.
REQ-034 Enter SET_HR, 30 ticks without presses -> RUN, time_ow never asserted, blink toggled 29 times then 0.
REQ-035 Captured time_out hour=27 -> edit hour 0; rst_n low mid-LOAD -> time_ow 0 same cycle, state RUN, all outputs 0.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock time-setting controller.
// A time value is packed as {hour[4:0], min[5:0], sec[5:0]}.
package clock_ctrl_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int TIME_W = HOUR_W + MIN_W + SEC_W;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SET_HR,
    ST_SET_MIN,
    ST_SET_SEC,
    ST_LOAD
  } state_t;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HOUR = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_SEC  = 2'd3
  } field_sel_t;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } clock_time_t;

  // Out-of-range fields read from the live clock are treated as zero.
  function automatic clock_time_t sanitize_time(input clock_time_t t);
    clock_time_t r;
    r = t;
    if (t.hour > HOUR_MAX) r.hour = '0;
    if (t.min  > MIN_MAX)  r.min  = '0;
    if (t.sec  > SEC_MAX)  r.sec  = '0;
    return r;
  endfunction

endpackage

// File: rtl/field_wrap_inc.sv
// Increment a time field by one, wrapping to zero past its maximum.
module field_wrap_inc #(
  parameter int W = 6
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] max,
  output logic [W-1:0] value_inc
);

  assign value_inc = (value >= max) ? '0 : value + W'(1);

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven time-setting controller: captures the live time, lets the user
// step hour/minute/second, then strobes the edited value back into the clock.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int LOAD_CYCLES = 2,
  parameter int TIMEOUT_S   = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_1hz,
  input  logic              mode_btn,
  input  logic              inc_btn,
  input  logic [TIME_W-1:0] time_out,
  output logic              time_ow,
  output logic [TIME_W-1:0] time_in,
  output logic [1:0]        edit_field,
  output logic              blink,
  output logic              busy
);

  localparam int IDLE_W = $clog2(TIMEOUT_S + 1);
  localparam int LOAD_W = $clog2(LOAD_CYCLES + 1);

  state_t            state, next_state;
  clock_time_t       edit_q, edit_d;
  clock_time_t       time_in_q;
  logic [IDLE_W-1:0] idle_cnt;
  logic [LOAD_W-1:0] load_cnt;
  logic              blink_q;

  logic              in_set, next_in_set;
  logic              any_btn;
  logic              timeout_hit;
  logic              load_done;
  logic [HOUR_W-1:0] hour_inc;
  logic [MIN_W-1:0]  min_inc;
  logic [SEC_W-1:0]  sec_inc;

  field_wrap_inc #(.W(HOUR_W)) u_hour_inc (
    .value     (edit_q.hour),
    .max       (HOUR_MAX),
    .value_inc (hour_inc)
  );

  field_wrap_inc #(.W(MIN_W)) u_min_inc (
    .value     (edit_q.min),
    .max       (MIN_MAX),
    .value_inc (min_inc)
  );

  field_wrap_inc #(.W(SEC_W)) u_sec_inc (
    .value     (edit_q.sec),
    .max       (SEC_MAX),
    .value_inc (sec_inc)
  );

  assign in_set      = (state == ST_SET_HR) || (state == ST_SET_MIN) || (state == ST_SET_SEC);
  assign next_in_set = (next_state == ST_SET_HR) || (next_state == ST_SET_MIN) ||
                       (next_state == ST_SET_SEC);
  assign any_btn     = mode_btn || inc_btn;
  // A press in the same cycle as the final tick keeps the edit alive.
  assign timeout_hit = in_set && tick_1hz && !any_btn &&
                       (idle_cnt == IDLE_W'(TIMEOUT_S - 1));
  assign load_done   = (load_cnt == LOAD_W'(LOAD_CYCLES - 1));

  // NOTE: async active-low reset in the sensitivity list; sequential state
  // always uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= next_state;
  end

  // NOTE: defaults first so every path assigns next_state (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      ST_RUN:     if (mode_btn) next_state = ST_SET_HR;
      ST_SET_HR:  if (mode_btn) next_state = ST_SET_MIN;
                  else if (timeout_hit) next_state = ST_RUN;
      ST_SET_MIN: if (mode_btn) next_state = ST_SET_SEC;
                  else if (timeout_hit) next_state = ST_RUN;
      ST_SET_SEC: if (mode_btn) next_state = ST_LOAD;
                  else if (timeout_hit) next_state = ST_RUN;
      ST_LOAD:    if (load_done) next_state = ST_RUN;
      default:    next_state = ST_RUN;
    endcase
  end

  always_comb begin
    time_ow    = (state == ST_LOAD);
    busy       = (state != ST_RUN);
    edit_field = FIELD_NONE;
    unique case (state)
      ST_SET_HR:  edit_field = FIELD_HOUR;
      ST_SET_MIN: edit_field = FIELD_MIN;
      ST_SET_SEC: edit_field = FIELD_SEC;
      default:    edit_field = FIELD_NONE;
    endcase
  end

  // mode_btn wins over inc_btn, so increments only apply without a mode press.
  always_comb begin
    edit_d = edit_q;
    unique case (state)
      ST_RUN:     if (mode_btn) edit_d = sanitize_time(clock_time_t'(time_out));
      ST_SET_HR:  if (!mode_btn && inc_btn) edit_d.hour = hour_inc;
      ST_SET_MIN: if (!mode_btn && inc_btn) edit_d.min  = min_inc;
      ST_SET_SEC: if (!mode_btn && inc_btn) edit_d.sec  = sec_inc;
      default:    edit_d = edit_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) edit_q <= '0;
    else        edit_q <= edit_d;
  end

  // Entering SET_HR always comes with a mode press, which clears the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       idle_cnt <= '0;
    else if (any_btn || !next_in_set) idle_cnt <= '0;
    else if (tick_1hz)                idle_cnt <= idle_cnt + IDLE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               load_cnt <= '0;
    else if (state != ST_LOAD || load_done)   load_cnt <= '0;
    else                                      load_cnt <= load_cnt + LOAD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        blink_q <= 1'b0;
    else if (next_state != state)      blink_q <= 1'b0;
    else if (tick_1hz && in_set)       blink_q <= ~blink_q;
  end

  // time_in is latched on LOAD entry and then held until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         time_in_q <= '0;
    else if (state == ST_SET_SEC && next_state == ST_LOAD) time_in_q <= edit_q;
  end

  assign blink   = blink_q;
  assign time_in = time_in_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: directed scenarios plus random button
// traffic, checked against a behavioural model of the setting procedure.
module tb_clock_set_ctrl;
  import clock_ctrl_pkg::*;

  localparam int LOAD_CYCLES = 2;
  localparam int TIMEOUT_S   = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        mode_btn = 1'b0;
  logic        inc_btn = 1'b0;
  logic [16:0] time_out = '0;
  logic        time_ow;
  logic [16:0] time_in;
  logic [1:0]  edit_field;
  logic        blink;
  logic        busy;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .LOAD_CYCLES (LOAD_CYCLES),
    .TIMEOUT_S   (TIMEOUT_S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1hz   (tick_1hz),
    .mode_btn   (mode_btn),
    .inc_btn    (inc_btn),
    .time_out   (time_out),
    .time_ow    (time_ow),
    .time_in    (time_in),
    .edit_field (edit_field),
    .blink      (blink),
    .busy       (busy)
  );

  typedef struct packed {
    logic        ow;
    logic [16:0] tin;
    logic [1:0]  field;
    logic        blink;
    logic        busy;
  } obs_t;

  obs_t        status_q[$];
  logic [16:0] load_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Model: phase 0=running, 1..3=editing hour/min/sec, 4=loading.
  int          m_phase, m_h, m_m, m_s, m_idle, m_left;
  bit          m_blink;
  logic [16:0] m_tin;
  logic [16:0] tout = '0;
  bit          hold_rst = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [16:0] pack_time(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.ow    = (m_phase == 4);
    o.tin   = m_tin;
    o.field = (m_phase >= 1 && m_phase <= 3) ? 2'(m_phase) : 2'd0;
    o.blink = m_blink;
    o.busy  = (m_phase != 0);
    return o;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_h = 0; m_m = 0; m_s = 0;
    m_idle = 0; m_left = 0; m_blink = 0; m_tin = '0;
  endtask

  task automatic model_step(input bit m, input bit i, input bit t, input logic [16:0] tv);
    int th, tm, ts;
    th = int'(tv[16:12]); tm = int'(tv[11:6]); ts = int'(tv[5:0]);
    case (m_phase)
      0: if (m) begin
        m_h = (th > 23) ? 0 : th;
        m_m = (tm > 59) ? 0 : tm;
        m_s = (ts > 59) ? 0 : ts;
        m_phase = 1; m_idle = 0; m_blink = 0;
      end
      1, 2, 3: begin
        if (m) begin
          m_idle = 0; m_blink = 0;
          if (m_phase == 3) begin
            m_phase = 4; m_left = LOAD_CYCLES;
            m_tin = pack_time(m_h, m_m, m_s);
            load_q.push_back(m_tin);
          end else begin
            m_phase++;
          end
        end else if (i) begin
          if (m_phase == 1) m_h = (m_h + 1) % 24;
          if (m_phase == 2) m_m = (m_m + 1) % 60;
          if (m_phase == 3) m_s = (m_s + 1) % 60;
          m_idle = 0;
          if (t) m_blink = ~m_blink;
        end else if (t) begin
          if (m_idle == TIMEOUT_S - 1) begin
            m_phase = 0; m_idle = 0; m_blink = 0;
          end else begin
            m_idle++; m_blink = ~m_blink;
          end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_phase = 0;
      end
    endcase
  endtask

  // One clock of stimulus: drive at negedge, advance the model, queue the
  // outputs expected after the following rising edge.
  task automatic cycle(input bit m, input bit i, input bit t);
    @(negedge clk);
    rst_n    = !hold_rst;
    mode_btn = m;
    inc_btn  = i;
    tick_1hz = t;
    time_out = tout;
    if (!rst_n) model_reset();
    else        model_step(m, i, t, tout);
    status_q.push_back(model_obs());
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  // Full edit with no increments: mode x4 then let the load complete.
  task automatic plain_load(input logic [16:0] tv);
    tout = tv;
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(4);
  endtask

  // Monitor: compares every observed cycle and every load pulse.
  initial begin
    obs_t e;
    int   run_len;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (status_q.size() == 0) begin
        fail_now("status_q underflow");
      end else begin
        e = status_q.pop_front();
        check("time_ow",    32'(time_ow),    32'(e.ow));
        check("time_in",    32'(time_in),    32'(e.tin));
        check("edit_field", 32'(edit_field), 32'(e.field));
        check("blink",      32'(blink),      32'(e.blink));
        check("busy",       32'(busy),       32'(e.busy));
      end
      if (!rst_n) begin
        run_len = 0;
      end else if (time_ow) begin
        if (run_len == 0) begin
          if (load_q.size() == 0) fail_now("unexpected load pulse");
          else check("load_value", 32'(time_in), 32'(load_q.pop_front()));
        end
        run_len++;
      end else if (run_len > 0) begin
        check("pulse_len", 32'(run_len), 32'(LOAD_CYCLES));
        run_len = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit prev_blink, ow_seen;
    int toggles;

    model_reset();
    status_q.push_back(model_obs());
    idle_cycles(3);
    hold_rst = 1'b0;
    idle_cycles(2);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_time_in", 32'(time_in), 32'd0);

    // 12:34:56, three hour increments -> 15:34:56
    tout = pack_time(12, 34, 56);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    #1 check("enter_hr_field", 32'(edit_field), 32'd1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(4);
    #1 check("load_15_34_56", 32'(time_in), 32'(pack_time(15, 34, 56)));

    // Wraps: 23->0, 59->0, 59->0
    tout = pack_time(23, 59, 59);
    cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(4);
    #1 check("wrap_all", 32'(time_in), 32'(pack_time(0, 0, 0)));

    // Minute wrap leaves hour alone
    tout = pack_time(7, 59, 30);
    cycle(1'b1, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(4);
    #1 check("min_wrap", 32'(time_in), 32'(pack_time(7, 0, 30)));

    // mode+inc together in SET_MIN: advance, minute unchanged
    tout = pack_time(12, 34, 56);
    cycle(1'b1, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    #1 check("mode_inc_field", 32'(edit_field), 32'd3);
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(4);
    #1 check("mode_inc_value", 32'(time_in), 32'(pack_time(12, 34, 56)));

    // Timeout: 30 ticks with no press
    tout = pack_time(1, 2, 3);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    #1;
    prev_blink = blink; toggles = 0; ow_seen = 0;
    for (int k = 0; k < TIMEOUT_S; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      #1;
      if (busy && blink != prev_blink) toggles++;
      prev_blink = blink;
      ow_seen |= time_ow;
    end
    check("timeout_toggles", 32'(toggles), 32'd29);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_blink", 32'(blink), 32'd0);
    check("timeout_no_ow", 32'(ow_seen), 32'd0);
    check("timeout_time_in", 32'(time_in), 32'(pack_time(12, 34, 56)));

    // Out-of-range capture
    plain_load({5'd27, 6'd10, 6'd20});
    #1 check("hour27_capture", 32'(time_in), 32'(pack_time(0, 10, 20)));
    plain_load({5'd5, 6'd63, 6'd60});
    #1 check("min_sec_capture", 32'(time_in), 32'(pack_time(5, 0, 0)));

    // Reset in the second LOAD cycle
    tout = pack_time(9, 8, 7);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("pre_reset_ow", 32'(time_ow), 32'd1);
    hold_rst = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("rst_ow", 32'(time_ow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_field", 32'(edit_field), 32'd0);
    check("rst_blink", 32'(blink), 32'd0);
    check("rst_time_in", 32'(time_in), 32'd0);
    status_q.delete();
    load_q.delete();
    model_reset();
    status_q.push_back(model_obs());
    idle_cycles(2);
    hold_rst = 1'b0;
    idle_cycles(5);
    #1;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_time_in", 32'(time_in), 32'd0);

    // Random traffic, busy buttons
    for (int k = 0; k < 3000; k++) begin
      tout = {5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))};
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    end
    // Random traffic, sparse buttons and frequent ticks to reach timeouts
    for (int k = 0; k < 3000; k++) begin
      tout = {5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))};
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 1) == 0);
    end

    idle_cycles(6);
    @(negedge clk);
    #2;
    check("status_q_drained", 32'(status_q.size()), 32'd0);
    check("load_q_drained", 32'(load_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
